retro_wb_copy_initiator: RTL and testbench
==========================================

// Module: retro_wb_copy_initiator
// PURPOSE
//  Wishbone Classic Pipelined initiator: copies Length words from SrcAddr to DstAddr (cart cache fill, VRAM/RAM block move).
//  Works in chunks through an internal buffer: read chunk, then write chunk, repeat.
//  Drives any IWishbone target, e.g. BRAM (ACK one cycle after request, STALL tied 0) or stalling SRAM targets.
// PARAMETERS
//  AddressBusWidth  12  word address width; addresses wrap modulo 2**AddressBusWidth
//  DataBusWidth     1   bytes per word; SEL width
//  BufferDepth      16  words per chunk, power of 2, >=2
//  LengthWidth      12  width of Length (max copy 2**LengthWidth-1 words)
// PORTS
//  System.CLK         in   1        clock
//  System.RST_N       in   1        reset, asynchronous, active-low
//  Start              in   1        1-cycle copy request; sampled only in IDLE
//  SrcAddr            in   AddressBusWidth  first source word address (latched on Start)
//  DstAddr            in   AddressBusWidth  first destination word address (latched on Start)
//  Length             in   LengthWidth      word count (latched on Start)
//  Busy               out  1        high from cycle after accepted Start until Done
//  Done               out  1        1-cycle pulse, copy complete
//  Bus.CYC/STB/WE     out  1 each   Wishbone cycle/strobe/write-enable
//  Bus.ADDR           out  AddressBusWidth  word address
//  Bus.SEL            out  DataBusWidth     all ones while STB
//  Bus.DAT_ToTarget   out  8*DataBusWidth   write data
//  Bus.DAT_ToInitiator in  8*DataBusWidth   read data, valid with ACK
//  Bus.ACK/STALL      in   1 each   target acknowledge / stall
// BEHAVIOUR
//  Reset (async): state IDLE; CYC,STB,WE,Busy,Done=0; ADDR,SEL,DAT_ToTarget=0; counters cleared. All outputs registered.
//  States: IDLE -> RD -> GAP1 -> WR -> GAP2 -> (RD if remaining>0 else FIN) -> IDLE.
//  IDLE: Start=1: latch args; Length=0 -> FIN (Done next cycle, no bus activity); else RD. Start ignored outside IDLE.
//  Chunk = min(remaining, BufferDepth), fixed at entry to RD.
//  Request accepted on cycle with STB=1 and STALL=0; ADDR/DAT/WE held stable while STALL=1.
//  RD: CYC=1, WE=0; STB=1 until Chunk requests accepted, ADDR=src+issued (mod 2**AW).
//   Each ACK writes DAT_ToInitiator into buffer[acked]; acks arriving in issue order. Exit when acked==Chunk.
//  GAP1/GAP2: CYC=STB=0 for exactly one cycle (bus cycle boundary).
//  WR: CYC=1, WE=1; STB=1 until Chunk accepted, ADDR=dst+issued, DAT_ToTarget=buffer[issued]. Exit when acked==Chunk.
//  After WR: src+=Chunk, dst+=Chunk, remaining-=Chunk (mod address width).
//  ACK may arrive same cycle as a request is accepted; counters update in the same cycle.
//  Outstanding requests never exceed Chunk; ACK with CYC=0 ignored.
//  FIN: Done=1 for one cycle, Busy drops same cycle; next cycle IDLE, Start accepted.
//  Overlap: copy is chunk-by-chunk; correct for Dst<=Src or non-overlap; Dst>Src overlap within a chunk distance is undefined.
//  Reset mid-copy: outputs drop asynchronously (CYC=0 aborts bus cycle); in-flight ACKs discarded; no Done.
// TESTING
//  BRAM target, Src=0x010 (0x010..0x012=A1,B2,C3), Dst=0x100, Length=3 -> one RD/WR chunk, 0x100..0x102=A1,B2,C3, Done once, Busy 1 throughout.
//  Length=40, BufferDepth=16 -> chunks 16,16,8; exactly 40 read and 40 write requests; CYC low 1 cycle at each of 5 phase gaps.
//  Target STALL=1 on every other cycle, ACK 3 cycles late -> ADDR/DAT stable under stall, data correct, no extra requests.
//  Src=0xFFE, Length=4 -> reads 0xFFE,0xFFF,0x000,0x001 (wrap).
//  Length=0 -> Done 1 cycle after Start, CYC never asserted; Start during Busy -> ignored, copy unchanged.
//  Assert RST_N mid-RD -> CYC/STB/Busy 0 immediately, no Done; later Start runs a clean copy.

Source files
------------

// File: rtl/retro_wb_copy_initiator.sv
// Wishbone pipelined block-copy initiator: reads a chunk into a local buffer, then writes it out.
// Latency: first request one cycle after start; one idle bus cycle between every read and write phase.
// Backpressure: a stalled request holds addr/data/we; the phase ends only when every request is acked.
module retro_wb_copy_initiator #(
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int DATA_BUS_WIDTH    = 1,
    parameter int BUFFER_DEPTH      = 16,
    parameter int LENGTH_WIDTH      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  src_addr,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  dst_addr,
    input  logic [LENGTH_WIDTH-1:0]       length,
    output logic                          busy,
    output logic                          done,
    output logic                          cyc,
    output logic                          stb,
    output logic                          we,
    output logic [ADDRESS_BUS_WIDTH-1:0]  addr,
    output logic [DATA_BUS_WIDTH-1:0]     sel,
    output logic [8*DATA_BUS_WIDTH-1:0]   dat_to_target,
    input  logic [8*DATA_BUS_WIDTH-1:0]   dat_to_initiator,
    input  logic                          ack,
    input  logic                          stall
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int LW = LENGTH_WIDTH;
    localparam int DW = 8 * DATA_BUS_WIDTH;
    localparam int IW = $clog2(BUFFER_DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP1, S_WR, S_GAP2, S_FIN} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   src, src_n, dst, dst_n, addr_n;
    logic [LW-1:0]   remaining, rem_n;
    logic [CW-1:0]   chunk, chunk_n, issued, issued_n, acked, acked_n;
    logic            cyc_n, stb_n, we_n, busy_n, done_n;
    logic [DW-1:0]   dat_n;
    logic            accept, ack_v, buf_wr;
    logic [DW-1:0]   buffer [BUFFER_DEPTH];

    function automatic logic [CW-1:0] chunk_of(input logic [LW-1:0] n);
        if (n >= LW'(BUFFER_DEPTH)) return CW'(BUFFER_DEPTH);
        return CW'(n);
    endfunction

    always_comb begin
        state_n  = state;
        src_n    = src;
        dst_n    = dst;
        rem_n    = remaining;
        chunk_n  = chunk;
        issued_n = issued;
        acked_n  = acked;
        cyc_n    = cyc;
        stb_n    = stb;
        we_n     = we;
        addr_n   = addr;
        dat_n    = dat_to_target;
        busy_n   = busy;
        done_n   = 1'b0;
        buf_wr   = 1'b0;
        accept   = stb && !stall;
        ack_v    = cyc && ack;

        case (state)
            S_IDLE: begin
                if (start) begin
                    src_n = src_addr;
                    dst_n = dst_addr;
                    rem_n = length;
                    if (length == '0) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n  = S_RD;
                        chunk_n  = chunk_of(length);
                        issued_n = '0;
                        acked_n  = '0;
                        cyc_n    = 1'b1;
                        stb_n    = 1'b1;
                        we_n     = 1'b0;
                        addr_n   = src_addr;
                        busy_n   = 1'b1;
                    end
                end
            end
            S_RD, S_WR: begin
                // Issue and ack counters advance independently; an ack may land in the accept cycle.
                issued_n = issued + CW'(accept);
                acked_n  = acked + CW'(ack_v);
                buf_wr   = ack_v && (state == S_RD);
                stb_n    = issued_n < chunk;
                addr_n   = ((state == S_RD) ? src : dst) + AW'(issued_n);
                if (state == S_WR) dat_n = buffer[issued_n[IW-1:0]];
                if (acked_n == chunk) begin
                    cyc_n  = 1'b0;
                    stb_n  = 1'b0;
                    we_n   = 1'b0;
                    addr_n = '0;
                    dat_n  = '0;
                    if (state == S_RD) begin
                        state_n = S_GAP1;
                    end else begin
                        state_n = S_GAP2;
                        src_n   = src + AW'(chunk);
                        dst_n   = dst + AW'(chunk);
                        rem_n   = remaining - LW'(chunk);
                    end
                end
            end
            S_GAP1: begin
                state_n  = S_WR;
                issued_n = '0;
                acked_n  = '0;
                cyc_n    = 1'b1;
                stb_n    = 1'b1;
                we_n     = 1'b1;
                addr_n   = dst;
                dat_n    = buffer[0];
            end
            S_GAP2: begin
                if (remaining != '0) begin
                    state_n  = S_RD;
                    chunk_n  = chunk_of(remaining);
                    issued_n = '0;
                    acked_n  = '0;
                    cyc_n    = 1'b1;
                    stb_n    = 1'b1;
                    we_n     = 1'b0;
                    addr_n   = src;
                end else begin
                    state_n = S_FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            src           <= '0;
            dst           <= '0;
            remaining     <= '0;
            chunk         <= '0;
            issued        <= '0;
            acked         <= '0;
            cyc           <= 1'b0;
            stb           <= 1'b0;
            we            <= 1'b0;
            addr          <= '0;
            sel           <= '0;
            dat_to_target <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            src           <= src_n;
            dst           <= dst_n;
            remaining     <= rem_n;
            chunk         <= chunk_n;
            issued        <= issued_n;
            acked         <= acked_n;
            cyc           <= cyc_n;
            stb           <= stb_n;
            we            <= we_n;
            addr          <= addr_n;
            sel           <= {DATA_BUS_WIDTH{stb_n}};
            dat_to_target <= dat_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

    // Read data lands in ack order, so the ack count is the buffer slot.
    always_ff @(posedge clk) begin
        if (buf_wr) buffer[acked[IW-1:0]] <= dat_to_initiator;
    end

endmodule

// File: tb/tb_retro_wb_copy_initiator.sv
// Bench for retro_wb_copy_initiator: pipelined memory target with stall/latency knobs,
// plus a copy-semantics reference memory.
module tb_retro_wb_copy_initiator;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [11:0] length = '0;
    logic        busy, done, cyc, stb, we;
    logic [11:0] addr;
    logic [0:0]  sel;
    logic [7:0]  dat_to_target;
    logic [7:0]  dat_to_initiator;
    logic        ack, stall;

    int chk = 0;
    int fails = 0;

    always #5 clk = ~clk;

    retro_wb_copy_initiator #(
        .ADDRESS_BUS_WIDTH(12), .DATA_BUS_WIDTH(1), .BUFFER_DEPTH(DEPTH), .LENGTH_WIDTH(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done),
        .cyc(cyc), .stb(stb), .we(we), .addr(addr), .sel(sel),
        .dat_to_target(dat_to_target), .dat_to_initiator(dat_to_initiator),
        .ack(ack), .stall(stall)
    );

    // Target memory (written only by the bus model) and reference memory (written only by the model).
    logic [7:0] mem [0:4095];
    logic [7:0] ref_mem [0:4095];
    int         pq_due[$];
    logic [7:0] pq_dat[$];
    int         rd_log[$];
    int         wr_log[$];
    int         cnt = 0;
    int         lat = 1;
    int         stall_mode = 0;
    int         done_cnt = 0, cyc_cnt = 0, stab_err = 0, over_err = 0;
    int         gaps = 0, gap_len_err = 0, low_run = 0;
    bit         seen_high = 0, held = 0, mem_ready = 0;
    logic [11:0] h_addr;
    logic [7:0]  h_dat;
    logic        h_we;

    int   rd0, wr0, done0, cyc0, gaps0, gle0, stab0, over0, busy_err;
    logic busy_at_done;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            16:      return 8'hA1;
            17:      return 8'hB2;
            18:      return 8'hC3;
            default: return 8'((i * 37 + 11) ^ (i >> 4));
        endcase
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            if (!mem_ready) begin
                for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
                mem_ready = 1;
            end
            pq_due.delete();
            pq_dat.delete();
            ack = 1'b0;
            stall = 1'b0;
            dat_to_initiator = 8'h00;
            held = 0;
            seen_high = 0;
            low_run = 0;
        end else begin
            if (done) done_cnt++;
            if (cyc) cyc_cnt++;
            if (held) begin
                if (!(cyc && stb) || addr !== h_addr || we !== h_we || dat_to_target !== h_dat) stab_err++;
                held = 0;
            end
            if (cyc && ack && pq_due.size() > 0) begin
                void'(pq_due.pop_front());
                void'(pq_dat.pop_front());
            end
            if (cyc && stb && stall) begin
                held = 1;
                h_addr = addr;
                h_we = we;
                h_dat = dat_to_target;
            end else if (cyc && stb) begin
                pq_due.push_back(cnt + lat);
                if (we) begin
                    mem[addr] = dat_to_target;
                    wr_log.push_back(int'(addr));
                    pq_dat.push_back(8'h00);
                end else begin
                    rd_log.push_back(int'(addr));
                    pq_dat.push_back(mem[addr]);
                end
                if (pq_due.size() > DEPTH) over_err++;
            end
            if (!busy) begin
                seen_high = 0;
                low_run = 0;
            end else if (cyc) begin
                if (seen_high && low_run > 0) begin
                    gaps++;
                    if (low_run != 1) gap_len_err++;
                end
                seen_high = 1;
                low_run = 0;
            end else if (seen_high) begin
                low_run++;
            end
            cnt++;
            #1;
            ack = (pq_due.size() > 0) && (pq_due[0] <= cnt);
            dat_to_initiator = ack ? pq_dat[0] : 8'h00;
            case (stall_mode)
                1:       stall = ~stall;
                2:       stall = 1'($urandom_range(0, 1));
                default: stall = 1'b0;
            endcase
        end
    end

    task automatic model_copy(input int s, input int d, input int l);
        for (int i = 0; i < l; i++) ref_mem[(d + i) % 4096] = ref_mem[(s + i) % 4096];
    endtask

    function automatic int mem_diff();
        int e = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) e++;
        return e;
    endfunction

    function automatic int seq_diff(input int base, input int l, input bit w, input int first);
        int e;
        int q[$];
        if (w) q = wr_log; else q = rd_log;
        e = (q.size() - first != l) ? 1 : 0;
        for (int i = first; i < q.size(); i++) if (q[i] != ((base + i - first) % 4096)) e++;
        return e;
    endfunction

    task automatic run_copy(input int s, input int d, input int l, input int inject,
                            output int n, output bit to);
        rd0 = rd_log.size(); wr0 = wr_log.size(); done0 = done_cnt; cyc0 = cyc_cnt;
        gaps0 = gaps; gle0 = gap_len_err; stab0 = stab_err; over0 = over_err; busy_err = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s[11:0]; dst_addr = d[11:0]; length = l[11:0];
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            if (busy !== 1'b1) busy_err++;
            if (n == inject) begin
                start = 1'b1; src_addr = s[11:0] ^ 12'h5A5; dst_addr = 12'h0; length = 12'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        to = (n >= 3000);
        busy_at_done = busy;
        repeat (3) @(negedge clk);
        model_copy(s, d, l);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk++; if ({cyc, stb, we, busy, done} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {cyc, stb, we, busy, done}); end
        chk++; if (addr !== 12'h0) begin fails++; $display("FAIL reset_addr: got %h want 000", addr); end
        chk++; if ({sel, dat_to_target} !== 9'h0) begin fails++; $display("FAIL reset_sel_dat: got %h want 000", {sel, dat_to_target}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk++; if ({cyc, stb, busy, done} !== 4'b0) begin fails++; $display("FAIL idle_ctrl: got %b want 0000", {cyc, stb, busy, done}); end
    endtask

    task automatic test_basic();
        int n; bit to;
        run_copy(12'h010, 12'h100, 3, -1, n, to);
        chk++; if (to) begin fails++; $display("FAIL basic_timeout: got %0d cycles want done", n); end
        chk++; if (mem[12'h100] !== 8'hA1) begin fails++; $display("FAIL basic_w0: got %h want a1", mem[12'h100]); end
        chk++; if (mem[12'h101] !== 8'hB2) begin fails++; $display("FAIL basic_w1: got %h want b2", mem[12'h101]); end
        chk++; if (mem[12'h102] !== 8'hC3) begin fails++; $display("FAIL basic_w2: got %h want c3", mem[12'h102]); end
        chk++; if (done_cnt - done0 != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", done_cnt - done0); end
        chk++; if (busy_err != 0) begin fails++; $display("FAIL basic_busy: got %0d low cycles want 0", busy_err); end
        chk++; if (busy_at_done !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        chk++; if (seq_diff(12'h010, 3, 0, rd0) != 0 || seq_diff(12'h100, 3, 1, wr0) != 0) begin
            fails++; $display("FAIL basic_reqs: got rd=%0d wr=%0d want 3/3", rd_log.size() - rd0, wr_log.size() - wr0); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL basic_mem: got %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_chunks();
        int n; bit to;
        run_copy(12'h200, 12'h400, 40, -1, n, to);
        chk++; if (to) begin fails++; $display("FAIL chunks_timeout: got %0d cycles want done", n); end
        chk++; if (rd_log.size() - rd0 != 40) begin fails++; $display("FAIL chunks_rd: got %0d want 40", rd_log.size() - rd0); end
        chk++; if (wr_log.size() - wr0 != 40) begin fails++; $display("FAIL chunks_wr: got %0d want 40", wr_log.size() - wr0); end
        chk++; if (gaps - gaps0 != 5) begin fails++; $display("FAIL chunks_gaps: got %0d want 5", gaps - gaps0); end
        chk++; if (gap_len_err != gle0) begin fails++; $display("FAIL chunks_gap_len: got %0d long gaps want 0", gap_len_err - gle0); end
        chk++; if (seq_diff(12'h200, 40, 0, rd0) + seq_diff(12'h400, 40, 1, wr0) != 0) begin
            fails++; $display("FAIL chunks_addr_seq: got %0d errors want 0", seq_diff(12'h200, 40, 0, rd0) + seq_diff(12'h400, 40, 1, wr0)); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL chunks_mem: got %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_stall();
        int n; bit to;
        stall_mode = 1; lat = 3;
        run_copy(12'h600, 12'h900, 21, -1, n, to);
        chk++; if (to) begin fails++; $display("FAIL stall_timeout: got %0d cycles want done", n); end
        chk++; if (stab_err != stab0) begin fails++; $display("FAIL stall_stable: got %0d unstable want 0", stab_err - stab0); end
        chk++; if (over_err != over0) begin fails++; $display("FAIL stall_outstanding: got %0d overflows want 0", over_err - over0); end
        chk++; if (seq_diff(12'h600, 21, 0, rd0) + seq_diff(12'h900, 21, 1, wr0) != 0) begin
            fails++; $display("FAIL stall_reqs: got rd=%0d wr=%0d want 21/21", rd_log.size() - rd0, wr_log.size() - wr0); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL stall_mem: got %0d bad words want 0", mem_diff()); end
        stall_mode = 0; lat = 1;
    endtask

    task automatic test_wrap();
        int n; bit to;
        int exp_rd[4] = '{4094, 4095, 0, 1};
        int bad = 0;
        run_copy(12'hFFE, 12'h300, 4, -1, n, to);
        if (rd_log.size() - rd0 != 4) bad = 100;
        else for (int i = 0; i < 4; i++) if (rd_log[rd0 + i] != exp_rd[i]) bad++;
        chk++; if (bad != 0) begin fails++; $display("FAIL wrap_rd_addr: got %0d errors want 0", bad); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL wrap_mem: got %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_zero_len();
        int n; bit to;
        run_copy(12'h123, 12'h456, 0, -1, n, to);
        chk++; if (n != 0) begin fails++; $display("FAIL zero_done_latency: got %0d want 0 extra cycles", n); end
        chk++; if (cyc_cnt != cyc0) begin fails++; $display("FAIL zero_cyc: got %0d cyc cycles want 0", cyc_cnt - cyc0); end
        chk++; if (done_cnt - done0 != 1) begin fails++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - done0); end
    endtask

    task automatic test_start_ignored();
        int n; bit to;
        run_copy(12'hA00, 12'hB00, 20, 5, n, to);
        chk++; if (seq_diff(12'hA00, 20, 0, rd0) + seq_diff(12'hB00, 20, 1, wr0) != 0) begin
            fails++; $display("FAIL ignored_reqs: got rd=%0d wr=%0d want 20/20", rd_log.size() - rd0, wr_log.size() - wr0); end
        chk++; if (done_cnt - done0 != 1) begin fails++; $display("FAIL ignored_done: got %0d want 1", done_cnt - done0); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL ignored_mem: got %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_reset_mid();
        int n = 0; bit to; int d0, w0, r0;
        d0 = done_cnt; w0 = wr_log.size(); r0 = rd_log.size();
        @(negedge clk);
        start = 1'b1; src_addr = 12'h500; dst_addr = 12'h700; length = 12'd40;
        @(negedge clk);
        start = 1'b0;
        while (rd_log.size() - r0 < 3 && n < 100) begin @(negedge clk); n++; end
        chk++; if (n >= 100) begin fails++; $display("FAIL rstmid_timeout: got %0d reads want 3", rd_log.size() - r0); end
        #2 rst_n = 1'b0;
        #1;
        chk++; if ({cyc, stb, busy} !== 3'b0) begin fails++; $display("FAIL rstmid_drop: got %b want 000", {cyc, stb, busy}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk++; if (done_cnt != d0 || wr_log.size() != w0) begin
            fails++; $display("FAIL rstmid_no_done: got done=%0d writes=%0d want 0/0", done_cnt - d0, wr_log.size() - w0); end
        run_copy(12'h500, 12'h700, 40, -1, n, to);
        chk++; if (to || done_cnt - done0 != 1) begin fails++; $display("FAIL rstmid_rerun_done: got %0d want 1", done_cnt - done0); end
        chk++; if (mem_diff() != 0) begin fails++; $display("FAIL rstmid_rerun_mem: got %0d bad words want 0", mem_diff()); end
    endtask

    task automatic test_random();
        int n; bit to; int s, d, l, nch;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 4095);
            l = $urandom_range(1, 70);
            d = (s + l + $urandom_range(0, 2000)) % 4096;
            stall_mode = $urandom_range(0, 2);
            lat = $urandom_range(1, 4);
            nch = (l + DEPTH - 1) / DEPTH;
            run_copy(s, d, l, -1, n, to);
            chk++; if (to || done_cnt - done0 != 1) begin fails++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt - done0); end
            chk++; if (seq_diff(s, l, 0, rd0) + seq_diff(d, l, 1, wr0) != 0) begin
                fails++; $display("FAIL rand%0d_reqs: got rd=%0d wr=%0d want %0d", it, rd_log.size() - rd0, wr_log.size() - wr0, l); end
            chk++; if (gaps - gaps0 != 2 * nch - 1 || gap_len_err != gle0) begin
                fails++; $display("FAIL rand%0d_gaps: got %0d want %0d", it, gaps - gaps0, 2 * nch - 1); end
            chk++; if (stab_err != stab0 || over_err != over0 || busy_err != 0) begin
                fails++; $display("FAIL rand%0d_protocol: got stab=%0d over=%0d busy=%0d want 0", it, stab_err - stab0, over_err - over0, busy_err); end
            chk++; if (mem_diff() != 0) begin fails++; $display("FAIL rand%0d_mem: got %0d bad words want 0", it, mem_diff()); end
        end
        stall_mode = 0; lat = 1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_basic();
        test_chunks();
        test_stall();
        test_wrap();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

endmodule
